// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLL DRP reconfiguration controller.
// PLL_DRP_CTRL_VERIFY_EN adds the read-back verify states to the state encoding.
package pll_drp_pkg;

    localparam int unsigned DRP_ADDR_W = 7;
    localparam int unsigned DRP_DATA_W = 16;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StRstWait  = 4'd1,
        StRd       = 4'd2,
        StRdWait   = 4'd3,
        StWr       = 4'd4,
        StWrWait   = 4'd5,
        StRelease  = 4'd6,
        StLockWait = 4'd7,
        StFinish   = 4'd8
`ifdef PLL_DRP_CTRL_VERIFY_EN
        ,
        StVrd      = 4'd9,
        StVrdWait  = 4'd10
`endif
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DRDY_TO = 2'd1;
    localparam logic [1:0] ERR_LOCK_TO = 2'd2;
    localparam logic [1:0] ERR_VERIFY  = 2'd3;

    // Commonly reprogrammed PLL DRP registers.
    localparam logic [6:0] ADDR_CLKOUT0_REG1  = 7'h08;
    localparam logic [6:0] ADDR_CLKFBOUT_REG1 = 7'h14;
    localparam logic [6:0] ADDR_DIVCLK        = 7'h16;
    localparam logic [6:0] ADDR_LOCK_REG1     = 7'h18;
    localparam logic [6:0] ADDR_LOCK_REG2     = 7'h19;
    localparam logic [6:0] ADDR_LOCK_REG3     = 7'h1A;
    localparam logic [6:0] ADDR_FILT_REG1     = 7'h4E;
    localparam logic [6:0] ADDR_FILT_REG2     = 7'h4F;
    localparam logic [6:0] ADDR_POWER         = 7'h28;

    typedef struct packed {
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] mask;
        logic [DRP_DATA_W-1:0] data;
    } entry_t;

    // mask bit 1 keeps the current register bit, 0 takes the new data bit
    function automatic logic [DRP_DATA_W-1:0] drp_merge(input logic [DRP_DATA_W-1:0] rd,
                                                        input logic [DRP_DATA_W-1:0] mask,
                                                        input logic [DRP_DATA_W-1:0] data);
        return (rd & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/drp_access.sv
// Single DRP transaction engine: one-cycle DEN pulse, DRDY wait with timeout.
module drp_access
    import pll_drp_pkg::*;
#(
    parameter int unsigned DRDY_TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [DRP_ADDR_W-1:0] i_addr,
    input  logic [DRP_DATA_W-1:0] i_wdata,
    input  logic                  i_drdy,
    input  logic [DRP_DATA_W-1:0] i_do,
    output logic                  o_den,
    output logic                  o_dwe,
    output logic [DRP_ADDR_W-1:0] o_daddr,
    output logic [DRP_DATA_W-1:0] o_di,
    output logic                  o_ack,
    output logic                  o_timeout,
    output logic [DRP_DATA_W-1:0] o_rdata
);

    localparam int unsigned CNT_W = $clog2(DRDY_TIMEOUT + 1);

    logic                  r_den;
    logic                  r_dwe;
    logic                  r_wait;
    logic [DRP_ADDR_W-1:0] r_daddr;
    logic [DRP_DATA_W-1:0] r_di;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_ack;
    logic                  w_timeout;

    // DRDY during the DEN cycle itself is not a valid response
    assign w_ack     = r_wait && !r_den && i_drdy;
    assign w_timeout = r_wait && !w_ack && (r_cnt == CNT_W'(DRDY_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_den   <= 1'b0;
            r_dwe   <= 1'b0;
            r_wait  <= 1'b0;
            r_daddr <= '0;
            r_di    <= '0;
            r_cnt   <= '0;
        end else begin
            r_den <= i_req;
            r_dwe <= i_req && i_we;
            if (i_req) begin
                r_daddr <= i_addr;
                if (i_we) begin
                    r_di <= i_wdata;
                end
                r_wait <= 1'b1;
                r_cnt  <= '0;
            end else if (w_ack || w_timeout) begin
                r_wait <= 1'b0;
            end else if (r_wait && (r_cnt != CNT_W'(DRDY_TIMEOUT - 1))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_den     = r_den;
    assign o_dwe     = r_dwe;
    assign o_daddr   = r_daddr;
    assign o_di      = r_di;
    assign o_ack     = w_ack;
    assign o_timeout = w_timeout;
    assign o_rdata   = i_do;

endmodule

// File: rtl/pll_drp_ctrl.sv
// PLL DRP reconfiguration sequencer: table-driven read-modify-write under PLL reset, then lock wait.
// Defining PLL_DRP_CTRL_VERIFY_EN adds a read-back check after every write.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int unsigned ENTRIES      = 8,
    parameter int unsigned IDX_W        = 3,
    parameter int unsigned RST_HOLD     = 4,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic             i_dclk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [IDX_W-1:0] i_cfg_idx,
    input  logic [6:0]       i_cfg_addr,
    input  logic [15:0]      i_cfg_mask,
    input  logic [15:0]      i_cfg_data,
    input  logic [IDX_W:0]   i_cfg_count,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_err_code,
    output logic             o_pll_rst,
    input  logic             i_locked,
    output logic [6:0]       o_daddr,
    output logic             o_den,
    output logic             o_dwe,
    output logic [15:0]      o_di,
    input  logic [15:0]      i_do,
    input  logic             i_drdy
);

    localparam int unsigned    CNT_MAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
    localparam int unsigned    CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W:0] N_MAX   = (IDX_W + 1)'(ENTRIES);

    state_t           r_state, w_state_d;
    entry_t           r_table [ENTRIES];
    logic [IDX_W:0]   r_n, r_idx, w_idx_d, w_n_start;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [1:0]       r_err, w_err_d;
    logic             r_pll_rst, w_pll_rst_d;
    logic             w_busy, w_start_ok;
    logic             w_req, w_req_we, w_ack, w_timeout;
    logic [6:0]       w_req_addr;
    logic [15:0]      w_req_wdata, w_rdata, w_di;

    assign w_busy     = (r_state != StIdle) && (r_state != StFinish);
    assign w_start_ok = i_start && !w_busy;
    assign w_n_start  = (i_cfg_count > N_MAX) ? N_MAX : i_cfg_count;

    // Table has no reset; contents survive a mid-sequence reset.
    always_ff @(posedge i_dclk) begin
        if (i_cfg_we && !w_busy) begin
            r_table[i_cfg_idx] <= '{addr: i_cfg_addr, mask: i_cfg_mask, data: i_cfg_data};
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_err_d     = r_err;
        w_req       = 1'b0;
        w_req_we    = 1'b0;
        w_req_wdata = drp_merge(w_rdata, r_table[r_idx[IDX_W-1:0]].mask,
                                r_table[r_idx[IDX_W-1:0]].data);
        case (r_state)
            StIdle, StFinish: begin
                w_state_d = StIdle;
                if (i_start) begin
                    w_state_d = StRstWait;
                    w_idx_d   = '0;
                    w_err_d   = ERR_NONE;
                end
            end
            StRstWait: begin
                if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
                    if (r_n != '0) begin
                        w_state_d = StRd;
                        w_req     = 1'b1;
                    end else begin
                        w_state_d = StRelease;
                    end
                end
            end
            StRd: w_state_d = StRdWait;
            StRdWait: begin
                if (w_timeout) begin
                    w_state_d = StFinish;
                    w_err_d   = ERR_DRDY_TO;
                end else if (w_ack) begin
                    w_state_d = StWr;
                    w_req     = 1'b1;
                    w_req_we  = 1'b1;
                end
            end
            StWr: w_state_d = StWrWait;
            StWrWait: begin
                if (w_timeout) begin
                    w_state_d = StFinish;
                    w_err_d   = ERR_DRDY_TO;
                end else if (w_ack) begin
`ifdef PLL_DRP_CTRL_VERIFY_EN
                    w_state_d = StVrd;
                    w_req     = 1'b1;
`else
                    w_idx_d = r_idx + 1'b1;
                    if (w_idx_d < r_n) begin
                        w_state_d = StRd;
                        w_req     = 1'b1;
                    end else begin
                        w_state_d = StRelease;
                    end
`endif
                end
            end
`ifdef PLL_DRP_CTRL_VERIFY_EN
            StVrd: w_state_d = StVrdWait;
            StVrdWait: begin
                if (w_timeout) begin
                    w_state_d = StFinish;
                    w_err_d   = ERR_DRDY_TO;
                end else if (w_ack) begin
                    if (w_rdata != w_di) begin
                        w_state_d = StFinish;
                        w_err_d   = ERR_VERIFY;
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                        if (w_idx_d < r_n) begin
                            w_state_d = StRd;
                            w_req     = 1'b1;
                        end else begin
                            w_state_d = StRelease;
                        end
                    end
                end
            end
`endif
            StRelease: w_state_d = StLockWait;
            StLockWait: begin
                if (i_locked === 1'b1) begin
                    w_state_d = StFinish;
                end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_state_d = StFinish;
                    w_err_d   = ERR_LOCK_TO;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_req_addr = r_table[w_idx_d[IDX_W-1:0]].addr;

    // One counter serves the reset hold and the lock wait; the lock count includes RELEASE.
    always_comb begin
        w_cnt_d = r_cnt;
        if ((w_state_d != r_state) && ((w_state_d == StRstWait) || (w_state_d == StRelease))) begin
            w_cnt_d = '0;
        end else if (r_cnt != CNT_W'(CNT_MAX)) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    assign w_pll_rst_d = !(w_state_d inside {StIdle, StRelease, StLockWait, StFinish});

    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_n       <= '0;
            r_cnt     <= '0;
            r_err     <= ERR_NONE;
            r_pll_rst <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_cnt     <= w_cnt_d;
            r_err     <= w_err_d;
            r_pll_rst <= w_pll_rst_d;
            if (w_start_ok) begin
                r_n <= w_n_start;
            end
        end
    end

    drp_access #(
        .DRDY_TIMEOUT(DRDY_TIMEOUT)
    ) u_drp_access (
        .i_clk    (i_dclk),
        .i_rst_n  (i_rst_n),
        .i_req    (w_req),
        .i_we     (w_req_we),
        .i_addr   (w_req_addr),
        .i_wdata  (w_req_wdata),
        .i_drdy   (i_drdy),
        .i_do     (i_do),
        .o_den    (o_den),
        .o_dwe    (o_dwe),
        .o_daddr  (o_daddr),
        .o_di     (w_di),
        .o_ack    (w_ack),
        .o_timeout(w_timeout),
        .o_rdata  (w_rdata)
    );

    assign o_di       = w_di;
    assign o_busy     = w_busy;
    assign o_done     = (r_state == StFinish);
    assign o_err_code = r_err;
    assign o_pll_rst  = r_pll_rst;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed bench for pll_drp_ctrl with a behavioural DRP register file and PLL lock model.
module tb_pll_drp_ctrl;

`ifdef PLL_DRP_CTRL_VERIFY_EN
    localparam int ACC_PER = 3;
`else
    localparam int ACC_PER = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [6:0]  cfg_addr = '0;
    logic [15:0] cfg_mask = '0;
    logic [15:0] cfg_data = '0;
    logic [3:0]  cfg_count = '0;
    logic        start = 1'b0;
    logic        busy, done, pll_rst, den, dwe;
    logic [1:0]  err;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        locked = 1'b0;
    logic [15:0] drp_do = '0;
    logic        drdy = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // DRP / PLL model state
    int          cyc = 0;
    int          drdy_lat = 0;
    bit          drdy_off = 0;
    bit          corrupt = 0;
    bit          lock_en = 1;
    logic [15:0] mem [128];
    bit          pend_v = 0;
    int          pend = 0;
    logic [6:0]  pend_addr = '0;
    bit          pend_bad = 0;
    bit          last_wr = 0;
    bit          den_prev = 0;
    bit          pll_prev = 0;
    int          den_cnt = 0, den_rst = 0, den_b2b = 0, first_den_cyc = -1;
    int          rst_hi = 0, done_cnt = 0, done_cyc = 0, pll_fall_cyc = 0;
    logic        done_pll = 1'b0;
    logic [6:0]  den_addr[$];
    logic        den_we[$];
    logic [15:0] den_di[$];

    always #5 clk = ~clk;

    pll_drp_ctrl #(
        .ENTRIES     (8),
        .IDX_W       (3),
        .RST_HOLD    (4),
        .DRDY_TIMEOUT(64),
        .LOCK_TIMEOUT(100)
    ) dut (
        .i_dclk     (clk),
        .i_rst_n    (rst_n),
        .i_cfg_we   (cfg_we),
        .i_cfg_idx  (cfg_idx),
        .i_cfg_addr (cfg_addr),
        .i_cfg_mask (cfg_mask),
        .i_cfg_data (cfg_data),
        .i_cfg_count(cfg_count),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_err_code (err),
        .o_pll_rst  (pll_rst),
        .i_locked   (locked),
        .o_daddr    (daddr),
        .o_den      (den),
        .o_dwe      (dwe),
        .o_di       (di),
        .i_do       (drp_do),
        .i_drdy     (drdy)
    );

    // Responds one or more cycles after each DEN; DUT outputs only move on posedge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        drdy = 1'b0;
        if (pend_v) begin
            if (pend == 0) begin
                pend_v = 0;
                if (!drdy_off) begin
                    drdy = 1'b1;
                    drp_do = mem[pend_addr] ^ (pend_bad ? 16'h0001 : 16'h0000);
                end
            end else begin
                pend = pend - 1;
            end
        end
        if (den === 1'b1) begin
            den_cnt = den_cnt + 1;
            if (first_den_cyc < 0) first_den_cyc = cyc;
            if (pll_rst === 1'b1) den_rst = den_rst + 1;
            if (den_prev) den_b2b = den_b2b + 1;
            den_addr.push_back(daddr);
            den_we.push_back(dwe);
            den_di.push_back(di);
            if (dwe === 1'b1) mem[daddr] = di;
            pend_v = 1;
            pend = drdy_lat;
            pend_addr = daddr;
            pend_bad = corrupt && (dwe !== 1'b1) && last_wr;
            last_wr = (dwe === 1'b1);
        end
        den_prev = (den === 1'b1);
        if (pll_rst === 1'b1) rst_hi = rst_hi + 1;
        if (pll_prev && (pll_rst !== 1'b1)) pll_fall_cyc = cyc;
        pll_prev = (pll_rst === 1'b1);
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_pll = pll_rst;
        end
        locked = lock_en && (pll_rst !== 1'b1) && ((cyc - pll_fall_cyc) >= 2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        den_cnt = 0; den_rst = 0; den_b2b = 0; first_den_cyc = -1;
        rst_hi = 0; done_cnt = 0;
        den_addr.delete(); den_we.delete(); den_di.delete();
    endtask

    task automatic load(input logic [2:0] idx, input logic [6:0] a, input logic [15:0] m,
                        input logic [15:0] d);
        cfg_idx = idx; cfg_addr = a; cfg_mask = m; cfg_data = d; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run(input logic [3:0] cnt);
        cfg_count = cnt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != 0) break;
            step();
        end
        step();
        check_eq({tag, "_done_once"}, done_cnt, 1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[7'h08] = 16'h1234;
        mem[7'h16] = 16'h5678;
        mem[7'h4E] = 16'h0F0F;

        // reset values
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_outs", {busy, done, err, pll_rst, den, dwe}, 7'b0);
        check_eq("rst_daddr_di", {daddr, di}, 23'h0);
        step(); step();
        rst_n = 1'b1;
        step();

        // single entry read-modify-write
        clear_log();
        load(3'd0, 7'h08, 16'h1000, 16'h0041);
        run(4'd1);
        wait_done("t1", 200);
        check_eq("t1_den_cnt", den_cnt, ACC_PER);
        check_eq("t1_rd_addr", {den_we[0], den_addr[0]}, {1'b0, 7'h08});
        check_eq("t1_wr_addr", {den_we[1], den_addr[1]}, {1'b1, 7'h08});
        check_eq("t1_wr_di", den_di[1], 16'h1041);
        check_eq("t1_rst_during_den", den_rst, ACC_PER);
        check_eq("t1_err", err, 2'd0);
        check_eq("t1_busy_after", busy, 1'b0);

        // count 0: reset hold only
        clear_log();
        run(4'd0);
        wait_done("t2", 200);
        check_eq("t2_rst_hold", rst_hi, 4);
        check_eq("t2_no_den", den_cnt, 0);
        check_eq("t2_err", err, 2'd0);

        // DRDY never arrives
        clear_log();
        drdy_off = 1;
        load(3'd0, 7'h14, 16'h0000, 16'hAAAA);
        run(4'd1);
        wait_done("t3", 200);
        check_eq("t3_err", err, 2'd1);
        check_eq("t3_to_latency", done_cyc - first_den_cyc, 64);
        check_eq("t3_no_write", den_cnt, 1);
        check_eq("t3_pll_rst_low", done_pll, 1'b0);
        drdy_off = 0;

        // lock never arrives
        clear_log();
        lock_en = 0;
        run(4'd0);
        wait_done("t4", 300);
        check_eq("t4_err", err, 2'd2);
        check_eq("t4_lock_latency", done_cyc - pll_fall_cyc, 100);
        step(); step(); step();
        check_eq("t4_err_holds", err, 2'd2);
        lock_en = 1;

        // 3 entries with START and CFG_WE while busy
        clear_log();
        load(3'd0, 7'h16, 16'hFF00, 16'h00AB);
        load(3'd1, 7'h18, 16'h0000, 16'hBEEF);
        load(3'd2, 7'h4E, 16'hFFFF, 16'h1111);
        run(4'd3);
        check_eq("t5_err_cleared", err, 2'd0);
        step(); step();
        cfg_count = 4'd1; start = 1'b1;
        cfg_idx = 3'd1; cfg_addr = 7'h28; cfg_mask = 16'h0; cfg_data = 16'h0; cfg_we = 1'b1;
        step();
        start = 1'b0; cfg_we = 1'b0;
        wait_done("t5", 300);
        check_eq("t5_den_cnt", den_cnt, 3 * ACC_PER);
        check_eq("t5_addr0", den_addr[0], 7'h16);
        check_eq("t5_addr1", den_addr[ACC_PER], 7'h18);
        check_eq("t5_addr2", den_addr[2 * ACC_PER], 7'h4E);
        check_eq("t5_di0", den_di[1], 16'h56AB);
        check_eq("t5_di1", den_di[ACC_PER + 1], 16'hBEEF);
        check_eq("t5_di2", den_di[2 * ACC_PER + 1], 16'h0F0F);
        check_eq("t5_no_b2b_den", den_b2b, 0);
        clear_log();
        run(4'd3);
        wait_done("t5b", 300);
        check_eq("t5_table_addr1", den_addr[ACC_PER], 7'h18);
        check_eq("t5_table_di1", den_di[ACC_PER + 1], 16'hBEEF);

        // reset in WR_WAIT
        clear_log();
        drdy_lat = 5;
        load(3'd0, 7'h08, 16'h1000, 16'h0041);
        run(4'd1);
        for (int i = 0; i < 50; i++) begin
            if (den_cnt >= 2) break;
            step();
        end
        check_eq("t6_wr_issued", den_cnt, 2);
        step();
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_outs", {busy, done, err, pll_rst, den, dwe}, 7'b0);
        check_eq("t6_async_daddr_di", {daddr, di}, 23'h0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check_eq("t6_no_done", done_cnt, 0);
        drdy_lat = 0;
        clear_log();
        run(4'd1);
        wait_done("t6b", 200);
        check_eq("t6_fresh_err", err, 2'd0);
        check_eq("t6_fresh_den", den_cnt, ACC_PER);

`ifdef PLL_DRP_CTRL_VERIFY_EN
        // corrupted read-back
        clear_log();
        corrupt = 1;
        run(4'd1);
        wait_done("t7", 200);
        check_eq("t7_err", err, 2'd3);
        check_eq("t7_pll_rst_low", done_pll, 1'b0);
        corrupt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_drp_ctrl.md
Name: pll_drp_ctrl

Overview:
- Upstream driver for the PLL's dynamic reconfiguration (DRP) port.
- Host loads a small table of {address, mask, data} entries, then pulses START.
- Block holds the PLL in reset and runs a read-modify-write per entry over DADDR/DEN/DWE/DI/DO/DRDY.
- It then releases the PLL reset, waits for LOCKED, and reports completion or error.

Parameters:
- ENTRIES, 8, table depth (1-32).
- IDX_W, 3, table index width; must equal clog2(ENTRIES).
- RST_HOLD, 4, DCLK cycles PLL_RST stays high before the first DRP access (>=1).
- DRDY_TIMEOUT, 64, max DCLK cycles waiting for DRDY after a DEN pulse.
- LOCK_TIMEOUT, 65535, max DCLK cycles waiting for LOCKED after PLL_RST release.

Ports:
- DCLK  in  1  DRP clock; sole clock.
- RST_N  in  1  asynchronous active-low reset.
- CFG_WE  in  1  table write strobe.
- CFG_IDX  in  IDX_W  table entry index.
- CFG_ADDR  in  7  DRP register address for entry.
- CFG_MASK  in  16  bit=1 keeps the current register bit.
- CFG_DATA  in  16  new bits, used where mask=0.
- CFG_COUNT  in  IDX_W+1  number of entries to apply; sampled at START.
- START  in  1  single-cycle request.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle pulse at end of sequence (success or abort).
- ERR_CODE  out  2  0 none, 1 DRDY timeout, 2 lock timeout, 3 verify mismatch.
- PLL_RST  out  1  drives PLL RST (active high).
- LOCKED  in  1  PLL lock.
- DADDR  out  7  DRP address.
- DEN  out  1  DRP enable.
- DWE  out  1  DRP write enable.
- DI  out  16  DRP write data.
- DO  in  16  DRP read data.
- DRDY  in  1  DRP ready.

Behaviour:
- Reset values: BUSY=0, DONE=0, ERR_CODE=0, PLL_RST=0, DADDR=0, DEN=0, DWE=0, DI=0. Table contents are undefined after reset.
- Reset mid-sequence aborts immediately, with no DONE.
- Table write: on CFG_WE while !BUSY, entry[CFG_IDX] <= {CFG_ADDR, CFG_MASK, CFG_DATA}. CFG_WE while BUSY is ignored.
- START while BUSY is ignored.
- START while idle:
  - latch n = min(CFG_COUNT, ENTRIES);
  - clear ERR_CODE;
  - BUSY=1 and PLL_RST=1 from the next cycle.
- States:
  - IDLE -> RST_WAIT on START.
  - RST_WAIT (count RST_HOLD cycles) -> RD if n>0, else RELEASE.
  - RD: DEN=1, DWE=0, DADDR=entry.addr for exactly one cycle -> RD_WAIT.
  - RD_WAIT: on DRDY, latch rd = DO -> WR.
  - WR: DEN=1, DWE=1, DADDR=entry.addr, DI=(rd & mask) | (data & ~mask), one cycle -> WR_WAIT.
  - WR_WAIT: on DRDY, index+1 -> RD if index<n, else RELEASE.
  - RELEASE: PLL_RST=0, clear lock counter -> LOCK_WAIT.
  - LOCK_WAIT: LOCKED===1 -> FINISH.
  - FINISH: DONE=1, BUSY=0 -> IDLE.
- DEN is never high in two consecutive cycles. DRDY outside RD_WAIT/WR_WAIT is ignored.
- A DRDY coinciding with the DEN cycle is ignored; DRDY must arrive no earlier than the cycle after DEN.
- Timeouts:
  - Wait counter resets on each DEN.
  - Count reaching DRDY_TIMEOUT -> ERR_CODE=1, PLL_RST=0, go to FINISH (no lock wait).
  - LOCK_WAIT exceeding LOCK_TIMEOUT -> ERR_CODE=2 -> FINISH.
- ERR_CODE holds until the next accepted START.
- Minimum per-entry latency: 4 cycles (RD, RD_WAIT with DRDY one cycle after DEN, WR, WR_WAIT).
- Counters are sized to their parameter with no wrap: they saturate at the terminal compare.

Optional Feature:
- Macro PLL_DRP_CTRL_VERIFY_EN.
- Defined: after WR_WAIT, states VRD/VRD_WAIT re-read the same address.
  - If DO != the written DI: ERR_CODE=3, PLL_RST=0, go to FINISH.
  - DRDY timeout rules apply to the re-read.
  - Per-entry minimum becomes 6 cycles.
- Undefined: the verify states do not exist and ERR_CODE=3 is never produced.

Decomposition:
- Package pll_drp_pkg holds:
  - state encoding;
  - ERR_* codes;
  - PLL DRP address constants: CLKOUT0 ClkReg1 7'h08, CLKFBOUT ClkReg1 7'h14, DIVCLK 7'h16, lock regs 7'h18-7'h1A, filter regs 7'h4E/7'h4F, power 7'h28.
- One sub-module, drp_access:
  - single read or write transaction engine: DEN pulse, DRDY wait, timeout;
  - returns ack/timeout/rdata to the sequencer FSM.

Test Plan:
- Single entry {addr 7'h08, mask 16'h1000, data 16'h0041}, DO model returns 16'h1234 -> read of 7'h08, then write DI=16'h1041. PLL_RST high for the whole sequence; DONE pulse, ERR_CODE=0.
- CFG_COUNT=0 -> PLL_RST high for RST_HOLD=4 cycles, no DEN pulses. DONE after LOCKED rises.
- DRP model never asserts DRDY -> ERR_CODE=1 exactly 64 cycles after the first DEN. PLL_RST=0 and DONE pulse; no write issued.
- LOCKED held 0 with LOCK_TIMEOUT=100 -> ERR_CODE=2 on the DONE pulse, 100 cycles after PLL_RST falls.
- 3 entries loaded, START pulsed again while BUSY, plus a CFG_WE while BUSY -> second START ignored and the table is unchanged. Exactly 6 DEN pulses with addresses in order.
- RST_N low during WR_WAIT -> all outputs 0 asynchronously, no DONE. A fresh START afterwards completes normally. With VERIFY_EN and a corrupted re-read, expect ERR_CODE=3.
